game_result_tx: RTL and testbench
=================================

GAME_RESULT_TX -- requirements
Module: game_result_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200); legal values are 2 or more.
REQ-002 The block SHALL have parameter SCORE_W, default 14, meaning the width of the score input.
REQ-003 The block SHALL have parameter COMBO_W, default 7, meaning the width of the combo input.
REQ-004 clk  input  1  single clock for all sequential logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 send  input  1  single-cycle request to transmit a result record.
REQ-007 score  input  SCORE_W  final score, unsigned binary.
REQ-008 max_combo  input  COMBO_W  peak combo, unsigned binary.
REQ-009 tx  output  1  UART serial line: 8N1, LSB first, idles high.
REQ-010 busy  output  1  high from the cycle after a request is accepted until the record is finished.
REQ-011 done  output  1  one-cycle pulse when the final stop bit completes.

Function
REQ-012 A send sampled high while busy is low SHALL be accepted, and score and max_combo SHALL be latched on that edge.
REQ-013 A send sampled while busy is high SHALL be ignored: no queueing, no effect on the frame in progress.
REQ-014 Latched score values above 9999 SHALL clamp to 9999; latched max_combo values above 99 SHALL clamp to 99.
REQ-015 The record SHALL be exactly 13 ASCII bytes: 'S','=',d3,d2,d1,d0,' ','C','=',c1,c0,CR,LF.
REQ-016 Every digit in the record SHALL be zero-padded.
REQ-017 FSM states: IDLE, CONVERT, START, DATA, STOP.
REQ-018 IDLE -> CONVERT on acceptance.
REQ-019 CONVERT SHALL last exactly 16 cycles while the binary values are converted to BCD; CONVERT -> START afterwards.
REQ-020 START, DATA and STOP SHALL each hold tx for CLKS_PER_BIT cycles per bit: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-021 STOP -> START for the next byte while the byte index is below 12; the byte index increments modulo 13.
REQ-022 STOP -> IDLE after byte 12. done SHALL pulse and busy SHALL fall on the same cycle as that transition.
REQ-023 Latency: tx SHALL fall for the first start bit on the 17th cycle after the accepting edge.
REQ-024 Total busy time SHALL be 16 + 130*CLKS_PER_BIT cycles.
REQ-025 send asserted on the same cycle as done SHALL be accepted, since busy is already low that cycle; the next record SHALL follow with no extra idle gap beyond the CONVERT period.
REQ-026 tx SHALL be driven from a register (glitch-free).
REQ-027 The bit counter SHALL count 0..CLKS_PER_BIT-1 and wrap.

Reset
REQ-028 While rst_n is low: tx=1, busy=0, done=0, state=IDLE, byte index=0, bit and baud counters=0, latched values=0.
REQ-029 Reset asserted mid-frame SHALL abort immediately and drive tx high asynchronously; no partial byte SHALL resume after release.
REQ-030 After rst_n deasserts, the first send SHALL be accepted normally.

Structure
REQ-031 The ASCII constants ('S','=',' ','C',CR=0x0D,LF=0x0A), the state encoding, the 9999 and 99 clamp limits, and the 115200-baud default SHALL live in the shared game package.
REQ-032 Binary-to-BCD conversion SHALL be one sub-module, bin2bcd: serial double-dabble with start/ready handshake, finishing within 16 cycles for 14-bit input.
REQ-033 The combo value SHALL be converted on a second bin2bcd instance or zero-extended through the same instance; either way the 16-cycle CONVERT budget is fixed.
REQ-034 Target size: 150-300 lines RTL, excluding the package.

Verification (run with CLKS_PER_BIT=4)
REQ-035 score=1234, max_combo=7, send pulse -> UART monitor decodes 0x53 0x3D 0x31 0x32 0x33 0x34 0x20 0x43 0x3D 0x30 0x37 0x0D 0x0A; busy high for 16+520=536 cycles; exactly one done pulse.
REQ-036 score=12000, max_combo=120 -> "S=9999 C=99\r\n"; score=0, max_combo=0 -> "S=0000 C=00\r\n".
REQ-037 send re-pulsed at byte 3 with score=5555 -> ignored; the original record is completed unchanged and no second record follows.
REQ-038 rst_n pulsed low mid-byte 5 -> tx=1 and busy=0 within the reset window; line stays idle; a new send then produces a full correct record.
REQ-039 send asserted on the done cycle with score=42 -> second record "S=0042 ..." with its start bit on the 17th cycle after acceptance.
REQ-040 Timing check: every bit period measured on tx equals exactly 4 cycles.

Source files
------------

// File: rtl/game_result_tx_pkg.sv
// Shared constants, state encoding and record formatting for the game result UART.
// Latency: n/a (package only).
// Backpressure: n/a.
package game_result_tx_pkg;

  // UART timing defaults (50 MHz core clock, 115200 baud).
  localparam int CLK_HZ_DEFAULT       = 50_000_000;
  localparam int BAUD_DEFAULT         = 115_200;
  localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ_DEFAULT / BAUD_DEFAULT;

  // Display limits: four score digits, two combo digits.
  localparam int SCORE_MAX   = 9999;
  localparam int COMBO_MAX   = 99;
  localparam int SCORE_BIN_W = 14;
  localparam int COMBO_BIN_W = 7;

  // Record framing.
  localparam int REC_LAST = 12;

  // ASCII constants used in the record.
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Byte idx of "S=dddd C=dd\r\n"; digits are BCD nibbles turned into '0'..'9'.
  function automatic logic [7:0] rec_char(input logic [3:0] idx,
                                          input logic [15:0] sbcd,
                                          input logic [7:0]  cbcd);
    logic [7:0] c;
    case (idx)
      4'd0:    c = ASCII_S;
      4'd1:    c = ASCII_EQ;
      4'd2:    c = {4'h3, sbcd[15:12]};
      4'd3:    c = {4'h3, sbcd[11:8]};
      4'd4:    c = {4'h3, sbcd[7:4]};
      4'd5:    c = {4'h3, sbcd[3:0]};
      4'd6:    c = ASCII_SP;
      4'd7:    c = ASCII_C;
      4'd8:    c = ASCII_EQ;
      4'd9:    c = {4'h3, cbcd[7:4]};
      4'd10:   c = {4'h3, cbcd[3:0]};
      4'd11:   c = ASCII_CR;
      default: c = ASCII_LF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Serial double-dabble binary to BCD converter, one bit per cycle.
// Latency: BIN_W+1 cycles from i_start to o_rdy (15 for 14-bit input).
// Backpressure: none; i_start restarts the conversion, o_bcd holds until next start.
module bin2bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_rdy
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_adj;
  logic [CNT_W-1:0]    r_cnt;

  // Add 3 to every digit that is 5 or more before the next left shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CNT_W'(BIN_W);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};
      r_bin <= {r_bin[BIN_W-2:0], 1'b0};
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_bcd = r_bcd;
  assign o_rdy = (r_cnt == '0);

endmodule

// File: rtl/game_result_tx.sv
// Sends "S=dddd C=dd\r\n" over an 8N1 UART when send is pulsed while idle.
// Latency: start bit on the 17th cycle after acceptance; busy for 16+130*CLKS_PER_BIT cycles.
// Backpressure: send while busy is dropped (no queue); done pulses as busy falls.
module game_result_tx
  import game_result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SCORE_W      = 14,
  parameter int COMBO_W      = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               send,
  input  logic [SCORE_W-1:0] score,
  input  logic [COMBO_W-1:0] max_combo,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_cvt_cnt, w_cvt_nxt;
  logic [BAUD_W-1:0]      r_baud, w_baud_nxt;
  logic [2:0]             r_bit, w_bit_nxt;
  logic [3:0]             r_byte, w_byte_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic [SCORE_BIN_W-1:0] r_score, w_score_nxt;
  logic [COMBO_BIN_W-1:0] r_combo, w_combo_nxt;

  logic [SCORE_BIN_W-1:0] w_score_clamp;
  logic [COMBO_BIN_W-1:0] w_combo_clamp;
  logic [15:0]            w_score_bcd;
  logic [7:0]             w_combo_bcd;
  logic                   w_score_rdy;
  logic                   w_combo_rdy;
  logic                   w_cvt_start;
  logic                   w_baud_last;

  // Saturate to what four / two decimal digits can show.
  assign w_score_clamp = (32'(score) > SCORE_MAX) ? SCORE_BIN_W'(SCORE_MAX)
                                                  : SCORE_BIN_W'(score);
  assign w_combo_clamp = (32'(max_combo) > COMBO_MAX) ? COMBO_BIN_W'(COMBO_MAX)
                                                      : COMBO_BIN_W'(max_combo);

  // Converters start on the first CONVERT cycle, from the latched values.
  assign w_cvt_start = (r_state == ST_CONVERT) && (r_cvt_cnt == 4'd0);
  assign w_baud_last = (r_baud == BAUD_LAST);

  bin2bcd #(.BIN_W(SCORE_BIN_W), .DIGITS(4)) u_score_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_cvt_start),
    .i_bin   (r_score),
    .o_bcd   (w_score_bcd),
    .o_rdy   (w_score_rdy)
  );

  bin2bcd #(.BIN_W(COMBO_BIN_W), .DIGITS(2)) u_combo_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_cvt_start),
    .i_bin   (r_combo),
    .o_bcd   (w_combo_bcd),
    .o_rdy   (w_combo_rdy)
  );

  // Next-state and next-value logic for the whole transmitter.
  always_comb begin
    w_state_nxt = r_state;
    w_cvt_nxt   = r_cvt_cnt;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_score_nxt = r_score;
    w_combo_nxt = r_combo;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (send) begin
          w_state_nxt = ST_CONVERT;
          w_busy_nxt  = 1'b1;
          w_cvt_nxt   = 4'd0;
          w_byte_nxt  = 4'd0;
          w_score_nxt = w_score_clamp;
          w_combo_nxt = w_combo_clamp;
        end
      end
      ST_CONVERT: begin
        // Fixed 16-cycle window; the converters finish inside it.
        if (r_cvt_cnt == 4'd15) begin
          if (w_score_rdy && w_combo_rdy) begin
            w_state_nxt = ST_START;
            w_baud_nxt  = '0;
            w_tx_nxt    = 1'b0;
            w_shift_nxt = rec_char(r_byte, w_score_bcd, w_combo_bcd);
          end
        end else begin
          w_cvt_nxt = r_cvt_cnt + 4'd1;
        end
      end
      ST_START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_state_nxt = ST_DATA;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_byte == 4'(REC_LAST)) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_byte_nxt  = 4'd0;
          end else begin
            w_state_nxt = ST_START;
            w_byte_nxt  = r_byte + 4'd1;
            w_tx_nxt    = 1'b0;
            w_shift_nxt = rec_char(r_byte + 4'd1, w_score_bcd, w_combo_bcd);
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cvt_cnt <= '0;
      r_baud    <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_score   <= '0;
      r_combo   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cvt_cnt <= w_cvt_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_byte    <= w_byte_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_score   <= w_score_nxt;
      r_combo   <= w_combo_nxt;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_game_result_tx.sv
// Directed bench for game_result_tx with a 4-cycle bit period.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_result_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [13:0] score = '0;
  logic [6:0]  max_combo = '0;
  logic        tx;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  byte unsigned rx_q[$];
  int           start_q[$];
  int           done_cnt = 0;
  int           busy_cyc = 0;
  int           glitch_cnt = 0;
  int           ferr_cnt = 0;

  game_result_tx #(.CLKS_PER_BIT(4), .SCORE_W(14), .COMBO_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send      (send),
    .score     (score),
    .max_combo (max_combo),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: samples on falling edges, records bytes, start cycles, bit glitches.
  initial begin
    bit           active;
    int           k;
    int           st;
    logic         bitval;
    byte unsigned sh;
    active = 1'b0; k = 0; st = 0; bitval = 1'b1; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cyc++;
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1; k = 0; st = cyc; bitval = 1'b0; sh = 8'h00;
        end
      end else begin
        k++;
        if ((k % 4) == 0) bitval = tx;
        else if (tx !== bitval) glitch_cnt++;
        if (k >= 6 && k <= 34 && (k % 4) == 2) sh = {tx, sh[7:1]};
        if (k == 38) begin
          if (tx !== 1'b1) ferr_cnt++;
          rx_q.push_back(sh);
          start_q.push_back(st);
        end
        if (k == 39) active = 1'b0;
      end
    end
  end

  function automatic byte unsigned exp_byte(input string s, input int i);
    if (i < 11) return s[i];
    else if (i == 11) return 8'h0D;
    else return 8'h0A;
  endfunction

  task automatic clear_mon();
    @(posedge clk);
    #1;
    rx_q.delete(); start_q.delete();
    done_cnt = 0; busy_cyc = 0; glitch_cnt = 0; ferr_cnt = 0;
  endtask

  task automatic pulse_send(input int s, input int c, output int c0);
    @(negedge clk);
    score = 14'(s); max_combo = 7'(c); send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_bytes(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (rx_q.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL idle_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int c0; bit ok; string s;
    s = "S=1234 C=07";
    clear_mon();
    pulse_send(1234, 7, c0);
    wait_done(1, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout: got none expected done"); end
    repeat (40) @(negedge clk);
    checks++; if (rx_q.size() != 13) begin failures++; $display("FAIL basic_count: got %0d expected 13", rx_q.size()); end
    for (int i = 0; i < 13 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_byte(s, i)) begin
        failures++; $display("FAIL basic_byte%0d: got %02h expected %02h", i, rx_q[i], exp_byte(s, i));
      end
    end
    checks++; if (start_q.size() < 1 || start_q[0] != c0 + 16) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", (start_q.size() > 0) ? start_q[0] : -1, c0 + 16); end
    checks++; if (busy_cyc != 536) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 536", busy_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (glitch_cnt != 0) begin failures++; $display("FAIL basic_bit_period: got %0d glitches expected 0", glitch_cnt); end
    checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL basic_stop_bit: got %0d errors expected 0", ferr_cnt); end
  endtask

  task automatic test_clamp();
    int c0; bit ok; string s;
    int sv[2]; int cv[2]; string sx[2];
    sv[0] = 12000; cv[0] = 120; sx[0] = "S=9999 C=99";
    sv[1] = 0;     cv[1] = 0;   sx[1] = "S=0000 C=00";
    for (int t = 0; t < 2; t++) begin
      s = sx[t];
      clear_mon();
      pulse_send(sv[t], cv[t], c0);
      wait_done(1, 2000, ok);
      repeat (10) @(negedge clk);
      checks++; if (!ok || rx_q.size() != 13) begin failures++; $display("FAIL clamp%0d_count: got %0d expected 13", t, rx_q.size()); end
      for (int i = 0; i < 13 && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_byte(s, i)) begin
          failures++; $display("FAIL clamp%0d_byte%0d: got %02h expected %02h", t, i, rx_q[i], exp_byte(s, i));
        end
      end
    end
  endtask

  task automatic test_ignore_busy();
    int c0; int c1; bit ok; string s;
    s = "S=1234 C=07";
    clear_mon();
    pulse_send(1234, 7, c0);
    wait_bytes(3, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ignore_wait: got %0d bytes expected 3", rx_q.size()); end
    repeat (6) @(negedge clk);
    pulse_send(5555, 7, c1);
    wait_done(1, 2000, ok);
    repeat (200) @(negedge clk);
    checks++; if (rx_q.size() != 13) begin failures++; $display("FAIL ignore_count: got %0d expected 13", rx_q.size()); end
    for (int i = 0; i < 13 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_byte(s, i)) begin
        failures++; $display("FAIL ignore_byte%0d: got %02h expected %02h", i, rx_q[i], exp_byte(s, i));
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int c0; bit ok; string s;
    s = "S=4321 C=56";
    clear_mon();
    pulse_send(4321, 56, c0);
    wait_bytes(5, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_wait: got %0d bytes expected 5", rx_q.size()); end
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL rstmid_no_resume: got %0d bytes expected 5", rx_q.size()); end
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    clear_mon();
    pulse_send(4321, 56, c0);
    wait_done(1, 2000, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok || rx_q.size() != 13) begin failures++; $display("FAIL rstmid_count: got %0d expected 13", rx_q.size()); end
    for (int i = 0; i < 13 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_byte(s, i)) begin
        failures++; $display("FAIL rstmid_byte%0d: got %02h expected %02h", i, rx_q[i], exp_byte(s, i));
      end
    end
    checks++; if (start_q.size() < 1 || start_q[0] != c0 + 16) begin failures++; $display("FAIL rstmid_latency: got %0d expected %0d", (start_q.size() > 0) ? start_q[0] : -1, c0 + 16); end
  endtask

  task automatic test_back_to_back();
    int c0; int c1; bit ok; bit seen; string s;
    s = "S=0042 C=03";
    clear_mon();
    pulse_send(1234, 7, c0);
    seen = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL b2b_done_timeout: got none expected done"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_on_done: got %b expected 0", busy); end
    score = 14'd42; max_combo = 7'd3; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    c1 = cyc;
    wait_done(2, 2000, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok || rx_q.size() != 26) begin failures++; $display("FAIL b2b_count: got %0d expected 26", rx_q.size()); end
    for (int i = 0; i < 13 && (i + 13) < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i + 13] !== exp_byte(s, i)) begin
        failures++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, rx_q[i + 13], exp_byte(s, i));
      end
    end
    checks++; if (start_q.size() < 14 || start_q[13] != c1 + 16) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", (start_q.size() > 13) ? start_q[13] : -1, c1 + 16); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    checks++; if (glitch_cnt != 0) begin failures++; $display("FAIL b2b_bit_period: got %0d glitches expected 0", glitch_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
